// File: rtl/mem_port_ctrl.sv
// mem_port_ctrl
//   Byte-addressed request/response front end for the even/odd byte-bank
//   memory. Splits 8/16-bit accesses into per-bank word accesses, absorbs the
//   one-cycle synchronous read latency and returns little-endian data through a
//   single registered response slot with valid/ready backpressure.
//
//   Build option: MEM_PORT_UNALIGNED_EN
//     defined   - wide access at an odd address uses both banks in one access
//                 (odd bank = low byte, even bank word+1 = high byte).
//     undefined - wide access at an odd address touches no memory and returns
//                 rsp_err=1, rsp_rdata=0.
//
//   Ports
//     clk, rst_n                       clock, async active-low reset
//     req_valid/ready/addr/write/wide/wdata   request channel
//     rsp_valid/ready/rdata/err        response channel
//     read_addr_even/odd, read_data_even/odd  bank read ports (1-cycle latency)
//     write_addr/data/en_even/odd      bank write ports
//
//   state | meaning
//   ------+-----------------------------------------------------------
//   IDLE  | waiting for a request; read addresses hold their last value
//   RD    | bank data valid, moving it into the response slot
//   WR    | write strobe cycle (first cycle only), then post response
module mem_port_ctrl (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [15:0] req_addr,
   input  logic        req_write,
   input  logic        req_wide,
   input  logic [15:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [15:0] rsp_rdata,
   output logic        rsp_err,
   output logic [14:0] read_addr_even,
   output logic [14:0] read_addr_odd,
   input  logic [7:0]  read_data_even,
   input  logic [7:0]  read_data_odd,
   output logic [14:0] write_addr_even,
   output logic [7:0]  write_data_even,
   output logic        write_en_even,
   output logic [14:0] write_addr_odd,
   output logic [7:0]  write_data_odd,
   output logic        write_en_odd
);

   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] RD   = 2'd1;
   localparam logic [1:0] WR   = 2'd2;

   logic [1:0]  state;
   logic        ready_en;
   logic [14:0] rd_addr_even_q, rd_addr_odd_q;
   logic        lat_wide, lat_a0;
   logic        we_even_q, we_odd_q, wr_first, err_q;

   logic        slot_free, accept, accept_rd, misalign_err;
   logic [15:0] hi_addr;
   logic [14:0] addr_even_nxt, addr_odd_nxt;
   logic [7:0]  byte_lo, byte_hi;
   logic [15:0] rdata_nxt;

   assign slot_free = !rsp_valid || rsp_ready;
   // ready_en keeps req_ready low until the first edge after reset release
   assign req_ready = ready_en && (state == IDLE) && slot_free;
   assign accept    = req_valid && req_ready;

`ifdef MEM_PORT_UNALIGNED_EN
   assign misalign_err = 1'b0;
`else
   assign misalign_err = req_wide && req_addr[0];
`endif

   assign accept_rd = accept && !req_write && !misalign_err;

   // High byte lives at addr+1 (wraps at 0xFFFF). For aligned wide accesses
   // this is the same word as the low byte; for odd ones it is the next even word.
   assign hi_addr       = req_addr + 16'd1;
   assign addr_even_nxt = req_wide ? hi_addr[15:1] : req_addr[15:1];
   assign addr_odd_nxt  = req_addr[15:1];

   // Read address goes out in the acceptance cycle so data lands in RD.
   assign read_addr_even = accept_rd ? addr_even_nxt : rd_addr_even_q;
   assign read_addr_odd  = accept_rd ? addr_odd_nxt  : rd_addr_odd_q;

   assign byte_lo   = lat_a0 ? read_data_odd  : read_data_even;
   assign byte_hi   = lat_a0 ? read_data_even : read_data_odd;
   assign rdata_nxt = lat_wide ? {byte_hi, byte_lo} : {8'h00, byte_lo};

   assign write_en_even = (state == WR) && wr_first && we_even_q;
   assign write_en_odd  = (state == WR) && wr_first && we_odd_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state           <= IDLE;
         ready_en        <= 1'b0;
         rd_addr_even_q  <= '0;
         rd_addr_odd_q   <= '0;
         lat_wide        <= 1'b0;
         lat_a0          <= 1'b0;
         we_even_q       <= 1'b0;
         we_odd_q        <= 1'b0;
         wr_first        <= 1'b0;
         err_q           <= 1'b0;
         write_addr_even <= '0;
         write_addr_odd  <= '0;
         write_data_even <= '0;
         write_data_odd  <= '0;
         rsp_valid       <= 1'b0;
         rsp_rdata       <= '0;
         rsp_err         <= 1'b0;
      end else begin
         ready_en <= 1'b1;
         // Consumption frees the slot; a capture below in the same edge reloads it.
         if (rsp_valid && rsp_ready)
            rsp_valid <= 1'b0;

         case (state)
            IDLE: begin
               if (accept_rd) begin
                  state          <= RD;
                  rd_addr_even_q <= addr_even_nxt;
                  rd_addr_odd_q  <= addr_odd_nxt;
                  lat_wide       <= req_wide;
                  lat_a0         <= req_addr[0];
               end else if (accept) begin
                  // Writes and rejected misaligned accesses share the WR path.
                  state           <= WR;
                  wr_first        <= 1'b1;
                  err_q           <= misalign_err;
                  we_even_q       <= req_write && !misalign_err &&
                                     (!req_addr[0] || req_wide);
                  we_odd_q        <= req_write && !misalign_err &&
                                     (req_addr[0] || req_wide);
                  write_addr_even <= addr_even_nxt;
                  write_addr_odd  <= addr_odd_nxt;
                  write_data_even <= req_addr[0] ? req_wdata[15:8] : req_wdata[7:0];
                  write_data_odd  <= req_addr[0] ? req_wdata[7:0]  : req_wdata[15:8];
               end
            end
            RD: begin
               if (slot_free) begin
                  state     <= IDLE;
                  rsp_valid <= 1'b1;
                  rsp_rdata <= rdata_nxt;
                  rsp_err   <= 1'b0;
               end
            end
            WR: begin
               wr_first <= 1'b0;
               if (slot_free) begin
                  state     <= IDLE;
                  rsp_valid <= 1'b1;
                  rsp_rdata <= '0;
                  rsp_err   <= err_q;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_ctrl.sv
// Directed bench for mem_port_ctrl with a behavioural dual-bank memory.
// Works in both builds (MEM_PORT_UNALIGNED_EN defined or not).
module tb_mem_port_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        req_valid, req_ready, req_write, req_wide;
   logic [15:0] req_addr, req_wdata;
   logic        rsp_valid, rsp_ready, rsp_err;
   logic [15:0] rsp_rdata;
   logic [14:0] read_addr_even, read_addr_odd, write_addr_even, write_addr_odd;
   logic [7:0]  read_data_even, read_data_odd, write_data_even, write_data_odd;
   logic        write_en_even, write_en_odd;

   int n_chk = 0;
   int n_err = 0;

   logic [7:0]  mem [0:65535];
   logic        pre_we = 1'b0;
   logic [15:0] pre_addr = '0;
   logic [7:0]  pre_data = '0;
   int          we_even_cnt = 0;
   int          we_odd_cnt  = 0;

   always #5 clk = ~clk;

   mem_port_ctrl dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
      .req_write(req_write), .req_wide(req_wide), .req_wdata(req_wdata),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err),
      .read_addr_even(read_addr_even), .read_addr_odd(read_addr_odd),
      .read_data_even(read_data_even), .read_data_odd(read_data_odd),
      .write_addr_even(write_addr_even), .write_data_even(write_data_even),
      .write_en_even(write_en_even),
      .write_addr_odd(write_addr_odd), .write_data_odd(write_data_odd),
      .write_en_odd(write_en_odd)
   );

   always @(posedge clk) begin
      read_data_even <= mem[{read_addr_even, 1'b0}];
      read_data_odd  <= mem[{read_addr_odd, 1'b1}];
      if (write_en_even) begin
         mem[{write_addr_even, 1'b0}] <= write_data_even;
         we_even_cnt <= we_even_cnt + 1;
      end
      if (write_en_odd) begin
         mem[{write_addr_odd, 1'b1}] <= write_data_odd;
         we_odd_cnt <= we_odd_cnt + 1;
      end
      if (pre_we)
         mem[pre_addr] <= pre_data;
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic poke(input logic [15:0] a, input logic [7:0] d);
      @(negedge clk);
      pre_addr = a; pre_data = d; pre_we = 1'b1;
      @(negedge clk);
      pre_we = 1'b0;
   endtask

   // Present a request and return #1 after the edge that accepted it.
   task automatic issue(input logic [15:0] a, input logic w, input logic wd,
                        input logic [15:0] d);
      @(negedge clk);
      req_addr = a; req_write = w; req_wide = wd; req_wdata = d; req_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         #1;
         if (req_ready) break;
         @(negedge clk);
      end
      if (!req_ready) chk("req_tmo", 32'(req_ready), 32'h1);
      @(posedge clk);
      #1 req_valid = 1'b0;
   endtask

   task automatic get_rsp(output logic [15:0] d, output logic e);
      rsp_ready = 1'b1;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (rsp_valid) break;
      end
      if (!rsp_valid) chk("rsp_tmo", 32'(rsp_valid), 32'h1);
      d = rsp_rdata;
      e = rsp_err;
      @(posedge clk);
      #1;
   endtask

   task automatic do_read(input string tag, input logic [15:0] a, input logic wd,
                          input logic [15:0] exp_d, input logic exp_e);
      logic [15:0] d;
      logic        e;
      issue(a, 1'b0, wd, 16'h0);
      get_rsp(d, e);
      chk(tag, 32'(d), 32'(exp_d));
      chk({tag, "_err"}, 32'(e), 32'(exp_e));
   endtask

   task automatic do_write(input string tag, input logic [15:0] a, input logic wd,
                           input logic [15:0] wdat, input logic exp_e);
      logic [15:0] d;
      logic        e;
      issue(a, 1'b1, wd, wdat);
      get_rsp(d, e);
      chk({tag, "_rd"}, 32'(d), 32'h0);
      chk({tag, "_err"}, 32'(e), 32'(exp_e));
   endtask

   initial begin
      logic [15:0] d;
      logic        e, seen;
      int          ce, co;

      rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_write = 1'b0;
      req_wide = 1'b0; req_wdata = '0; rsp_ready = 1'b1;

      poke(16'h0100, 8'h11);
      poke(16'h0101, 8'h22);
      poke(16'h0102, 8'h33);
      poke(16'hFFFF, 8'hAA);
      poke(16'h0000, 8'h55);

      // reset state
      #1;
      chk("rst_req_ready", 32'(req_ready), 32'h0);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("rst_rsp_rdata", 32'(rsp_rdata), 32'h0);
      chk("rst_we", 32'({write_en_even, write_en_odd}), 32'h0);
      chk("rst_raddr", 32'({read_addr_even, read_addr_odd}), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      #1 chk("rel_req_ready_low", 32'(req_ready), 32'h0);
      @(posedge clk);
      #1 chk("rel_req_ready_high", 32'(req_ready), 32'h1);

      // 1: wide aligned read, N+2 latency
      @(negedge clk);
      req_addr = 16'h0100; req_write = 1'b0; req_wide = 1'b1; req_valid = 1'b1;
      #1;
      chk("t1_ready", 32'(req_ready), 32'h1);
      chk("t1_raddr_e", 32'(read_addr_even), 32'h080);
      chk("t1_raddr_o", 32'(read_addr_odd), 32'h080);
      @(negedge clk);
      req_valid = 1'b0;
      chk("t1_n1_valid", 32'(rsp_valid), 32'h0);
      chk("t1_n1_raddr", 32'(read_addr_even), 32'h080);
      @(negedge clk);
      chk("t1_n2_valid", 32'(rsp_valid), 32'h1);
      chk("t1_n2_rdata", 32'(rsp_rdata), 32'h2211);
      chk("t1_n2_err", 32'(rsp_err), 32'h0);
      @(posedge clk);
      #1;

      // 2: wide read at odd address
      ce = we_even_cnt; co = we_odd_cnt;
`ifdef MEM_PORT_UNALIGNED_EN
      @(negedge clk);
      req_addr = 16'h0101; req_write = 1'b0; req_wide = 1'b1; req_valid = 1'b1;
      #1;
      chk("t2_raddr_o", 32'(read_addr_odd), 32'h080);
      chk("t2_raddr_e", 32'(read_addr_even), 32'h081);
      req_valid = 1'b0;
      do_read("t2_rd", 16'h0101, 1'b1, 16'h3322, 1'b0);
`else
      do_read("t2_rd", 16'h0101, 1'b1, 16'h0000, 1'b1);
`endif
      chk("t2_we_cnt", 32'((we_even_cnt - ce) + (we_odd_cnt - co)), 32'h0);

      // 3: wide write at odd address
      ce = we_even_cnt; co = we_odd_cnt;
      issue(16'h0201, 1'b1, 1'b1, 16'hBEEF);
`ifdef MEM_PORT_UNALIGNED_EN
      chk("t3_we", 32'({write_en_even, write_en_odd}), 32'h3);
      chk("t3_waddr_o", 32'(write_addr_odd), 32'h100);
      chk("t3_wdata_o", 32'(write_data_odd), 32'hEF);
      chk("t3_waddr_e", 32'(write_addr_even), 32'h101);
      chk("t3_wdata_e", 32'(write_data_even), 32'hBE);
      get_rsp(d, e);
      chk("t3_rsp", 32'({e, d}), 32'h0);
      chk("t3_we_cnt", 32'((we_even_cnt - ce) + (we_odd_cnt - co)), 32'h2);
`else
      chk("t3_we", 32'({write_en_even, write_en_odd}), 32'h0);
      get_rsp(d, e);
      chk("t3_rsp", 32'({e, d}), 32'h10000);
      chk("t3_we_cnt", 32'((we_even_cnt - ce) + (we_odd_cnt - co)), 32'h0);
      ce = we_even_cnt; co = we_odd_cnt;
      do_write("t3_nw", 16'h0202, 1'b0, 16'h00BE, 1'b0);
      chk("t3_nw_even", 32'(we_even_cnt - ce), 32'h1);
      chk("t3_nw_odd", 32'(we_odd_cnt - co), 32'h0);
`endif
      do_read("t3_nr", 16'h0202, 1'b0, 16'h00BE, 1'b0);

      // 4: wrap at 0xFFFF
`ifdef MEM_PORT_UNALIGNED_EN
      @(negedge clk);
      req_addr = 16'hFFFF; req_write = 1'b0; req_wide = 1'b1; req_valid = 1'b1;
      #1;
      chk("t4_raddr_o", 32'(read_addr_odd), 32'h7FFF);
      chk("t4_raddr_e", 32'(read_addr_even), 32'h0000);
      req_valid = 1'b0;
      do_read("t4_rd", 16'hFFFF, 1'b1, 16'h55AA, 1'b0);
`else
      do_read("t4_rd", 16'hFFFF, 1'b1, 16'h0000, 1'b1);
`endif
      do_read("t4_nff", 16'hFFFF, 1'b0, 16'h00AA, 1'b0);
      do_read("t4_n00", 16'h0000, 1'b0, 16'h0055, 1'b0);

      // aligned wide write/readback
      ce = we_even_cnt; co = we_odd_cnt;
      do_write("aw", 16'h0300, 1'b1, 16'h1234, 1'b0);
      chk("aw_cnt", 32'({8'(we_even_cnt - ce), 8'(we_odd_cnt - co)}), 32'h0101);
      do_read("aw_rb", 16'h0300, 1'b1, 16'h1234, 1'b0);

      // 5: backpressure
      rsp_ready = 1'b0;
      issue(16'h0100, 1'b0, 1'b0, 16'h0);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (rsp_valid) break;
      end
      chk("t5_valid", 32'(rsp_valid), 32'h1);
      req_addr = 16'h0102; req_write = 1'b0; req_wide = 1'b0; req_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("t5_hold_rdata", 32'(rsp_rdata), 32'h0011);
         chk("t5_hold_ready", 32'(req_ready), 32'h0);
         chk("t5_hold_raddr", 32'(read_addr_even), 32'h080);
      end
      rsp_ready = 1'b1;
      #1;
      chk("t5_rel_ready", 32'(req_ready), 32'h1);
      chk("t5_rel_raddr", 32'(read_addr_even), 32'h081);
      @(posedge clk);
      #1 req_valid = 1'b0;
      @(negedge clk);
      chk("t5_rd_valid", 32'(rsp_valid), 32'h0);
      @(negedge clk);
      chk("t5_next", 32'({rsp_valid, rsp_rdata}), 32'h10033);
      @(posedge clk);
      #1;

      // 6: reset in RD, and reset with a pending response
      rsp_ready = 1'b1;
      issue(16'h0100, 1'b0, 1'b0, 16'h0);
      rst_n = 1'b0;
      #1;
      chk("t6_rst_valid", 32'(rsp_valid), 32'h0);
      chk("t6_rst_ready", 32'(req_ready), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         seen = seen | rsp_valid;
      end
      chk("t6_no_rsp", 32'(seen), 32'h0);
      chk("t6_ready_back", 32'(req_ready), 32'h1);

      rsp_ready = 1'b0;
      issue(16'h0101, 1'b0, 1'b0, 16'h0);
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (rsp_valid) break;
      end
      chk("t6b_pending", 32'({rsp_valid, rsp_rdata}), 32'h10022);
      rst_n = 1'b0;
      #1;
      chk("t6b_rst", 32'({rsp_valid, rsp_rdata}), 32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      rsp_ready = 1'b1;
      @(negedge clk);

      ce = we_even_cnt; co = we_odd_cnt;
      issue(16'h0401, 1'b1, 1'b0, 16'h005A);
      chk("t6_nw_en", 32'({write_en_even, write_en_odd}), 32'h1);
      chk("t6_nw_addr", 32'(write_addr_odd), 32'h200);
      get_rsp(d, e);
      chk("t6_nw_rsp", 32'({e, d}), 32'h0);
      chk("t6_nw_cnt", 32'({8'(we_even_cnt - ce), 8'(we_odd_cnt - co)}), 32'h0001);
      chk("t6_nw_mem", 32'(mem[16'h0401]), 32'h5A);
      do_read("t6_nr", 16'h0401, 1'b0, 16'h005A, 1'b0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end

endmodule
